param_stack: RTL and testbench
==============================

Name: param_stack

Overview:
- Parametrised LIFO stack; next-generation replacement for the fixed 8-bit call/data stack in the processor top.
- Stores return addresses (PC+1) and pushed accumulator values.
- Adds over the fixed stack: configurable width and depth, a simultaneous push/pop (replace-top) mode, an indexed peek read port, a level count, full/empty flags, and sticky overflow/underflow error flags.
- Instruction-decoder soft reset is a separate synchronous clear input.

Parameters:
- DATA_WIDTH, 8: width of each stack entry in bits.
- DEPTH, 8: number of entries; any value from 2 to 256, power of two not required.
- CNT_W, $clog2(DEPTH+1): localparam, width of the level counter; not overridable.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- CE  input  1  clock enable; when 0, all state holds and PUSH/POP/SOFT_CLR/CLR_ERR are ignored.
- SOFT_CLR  input  1  synchronous clear of stack contents pointer; driven by the decoder reset instruction.
- PUSH  input  1  push DATA_IN this cycle.
- POP  input  1  pop top entry this cycle.
- DATA_IN  input  DATA_WIDTH  value to push.
- DATA_OUT  output  DATA_WIDTH  current top-of-stack (combinational from stored state).
- PEEK_IDX  input  CNT_W  offset below top for peek read; 0 = top.
- PEEK_OUT  output  DATA_WIDTH  entry at (top − PEEK_IDX).
- PEEK_VALID  output  1  1 when PEEK_IDX < LEVEL.
- LEVEL  output  CNT_W  number of valid entries, 0..DEPTH.
- EMPTY  output  1  LEVEL == 0.
- FULL  output  1  LEVEL == DEPTH.
- OVF  output  1  sticky overflow error.
- UNF  output  1  sticky underflow error.
- CLR_ERR  input  1  synchronous clear of OVF/UNF.

Behaviour:
- Reset (nRST=0, asynchronous):
  - LEVEL=0, OVF=0, UNF=0, EMPTY=1, FULL=0.
  - DATA_OUT=0, PEEK_OUT=0, PEEK_VALID=0.
  - Entry storage need not be cleared.
- Priority on an enabled edge: SOFT_CLR > PUSH/POP.
  - SOFT_CLR=1: LEVEL←0; any PUSH/POP that cycle is ignored; OVF/UNF are unchanged.
- PUSH=1, POP=0:
  - If not FULL: entry[LEVEL]←DATA_IN, LEVEL←LEVEL+1.
  - If FULL: write dropped, LEVEL unchanged, OVF←1.
- POP=1, PUSH=0:
  - If not EMPTY: LEVEL←LEVEL−1. Popped data is DATA_OUT during the cycle before the edge.
  - If EMPTY: LEVEL stays 0, UNF←1.
- PUSH=1, POP=1 (replace-top, used by return-and-call):
  - If not EMPTY: entry[LEVEL−1]←DATA_IN, LEVEL unchanged, no error. Valid even when FULL.
  - If EMPTY: behaves as a plain push (LEVEL←1), no UNF.
- DATA_OUT = entry[LEVEL−1] when LEVEL>0, else all zeros.
  - Updated value is visible in the same cycle as the edge that changed it (zero-cycle read latency after the write edge).
- Peek port:
  - PEEK_OUT = entry[LEVEL−1−PEEK_IDX] when PEEK_VALID, else all zeros.
  - Purely combinational; has no effect on state.
- Error flags:
  - OVF/UNF stay set until CLR_ERR=1 on an enabled edge.
  - If CLR_ERR and a new error occur in the same cycle, the new error wins (the flag is set).
- CE=0: everything holds, including flags. Asynchronous reset still acts.
- Reset deasserted mid-operation: the first enabled edge after release sees LEVEL=0.
- Width rules:
  - LEVEL arithmetic uses CNT_W bits and never wraps, because guarded by FULL/EMPTY.
  - DEPTH=256 requires CNT_W=9.

Test Plan:
- Reset then 3 pushes 0x11, 0x22, 0x33 (CE=1) → LEVEL=3, DATA_OUT=0x33, EMPTY=0, FULL=0; PEEK_IDX=2 → PEEK_OUT=0x11, PEEK_VALID=1; PEEK_IDX=3 → PEEK_VALID=0, PEEK_OUT=0.
- DEPTH=8: push 0x01..0x08, then push 0xFF → FULL=1, LEVEL=8, DATA_OUT=0x08, OVF=1. Pop → LEVEL=7, DATA_OUT=0x07, OVF still 1. CLR_ERR → OVF=0.
- From empty: pop → UNF=1, LEVEL=0, DATA_OUT=0. Then PUSH+POP with 0x5A → LEVEL=1, DATA_OUT=0x5A, UNF remains 1.
- Full stack (8 entries), PUSH+POP with 0xAB → LEVEL=8, DATA_OUT=0xAB, OVF=0, PEEK_IDX=1 → 0x07.
- LEVEL=4, CE=0 with PUSH=1 → no change. SOFT_CLR+PUSH with CE=1 → LEVEL=0, EMPTY=1. Assert nRST low between clock edges while LEVEL=2 → LEVEL=0 immediately.
- Parameter sweep DATA_WIDTH=16, DEPTH=5: push 0x1234 ×5 → FULL=1, LEVEL=5 (CNT_W=3). Sixth push → OVF=1. Five pops → EMPTY=1, no UNF.

Source files
------------

// File: rtl/param_stack_if.sv
// Bus bundle for param_stack: command/data inputs from the owner, stack status back.
// Handshake: there is no ready/valid pair; a command (PUSH, POP, SOFT_CLR, CLR_ERR)
// is accepted on every rising edge with CE=1, and overflow/underflow are reported
// afterwards through the sticky OVF/UNF flags rather than by back-pressure.
interface param_stack_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  CE;
    logic                  SOFT_CLR;
    logic                  PUSH;
    logic                  POP;
    logic                  CLR_ERR;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [CNT_W-1:0]      PEEK_IDX;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic [DATA_WIDTH-1:0] PEEK_OUT;
    logic                  PEEK_VALID;
    logic [CNT_W-1:0]      LEVEL;
    logic                  EMPTY;
    logic                  FULL;
    logic                  OVF;
    logic                  UNF;

    modport master (
        output CE, SOFT_CLR, PUSH, POP, CLR_ERR, DATA_IN, PEEK_IDX,
        input  DATA_OUT, PEEK_OUT, PEEK_VALID, LEVEL, EMPTY, FULL, OVF, UNF
    );

    modport slave (
        input  CE, SOFT_CLR, PUSH, POP, CLR_ERR, DATA_IN, PEEK_IDX,
        output DATA_OUT, PEEK_OUT, PEEK_VALID, LEVEL, EMPTY, FULL, OVF, UNF
    );
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO call/data stack with replace-top, indexed peek, level count
// and sticky overflow/underflow flags.
module param_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    param_stack_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      level;
    logic                  ovf;
    logic                  unf;

    logic                  empty;
    logic                  full;
    logic                  push_only;
    logic                  pop_only;
    logic                  replace;
    logic                  wr_en;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         peek_idx;
    logic [CNT_W-1:0]      level_nxt;
    logic                  ovf_set;
    logic                  unf_set;

    assign empty     = (level == '0);
    assign full      = (level == CNT_W'(DEPTH));
    assign top_idx   = AW'(level - CNT_W'(1));
    assign peek_idx  = AW'(level - CNT_W'(1) - bus.PEEK_IDX);

    // SOFT_CLR masks the push/pop decode so it can neither move data nor raise errors.
    assign push_only = bus.PUSH & ~bus.POP & ~bus.SOFT_CLR;
    assign pop_only  = bus.POP & ~bus.PUSH & ~bus.SOFT_CLR;
    assign replace   = bus.PUSH & bus.POP & ~bus.SOFT_CLR;

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = AW'(level);
        level_nxt = level;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (bus.SOFT_CLR) begin
            level_nxt = '0;
        end else if (push_only) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en     = 1'b1;
                level_nxt = level + CNT_W'(1);
            end
        end else if (pop_only) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                level_nxt = level - CNT_W'(1);
            end
        end else if (replace) begin
            // Replace-top on an empty stack degenerates into a plain push into slot 0.
            wr_en = 1'b1;
            if (empty) begin
                level_nxt = CNT_W'(1);
            end else begin
                wr_idx = top_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (bus.CE) begin
            level <= level_nxt;
            ovf   <= ovf_set | (ovf & ~bus.CLR_ERR);
            unf   <= unf_set | (unf & ~bus.CLR_ERR);
        end
    end

    // Entry storage is deliberately left out of reset; reads are gated by LEVEL.
    always_ff @(posedge CLK) begin
        if (bus.CE && wr_en) begin
            mem[wr_idx] <= bus.DATA_IN;
        end
    end

    assign bus.LEVEL      = level;
    assign bus.EMPTY      = empty;
    assign bus.FULL       = full;
    assign bus.OVF        = ovf;
    assign bus.UNF        = unf;
    assign bus.DATA_OUT   = empty ? '0 : mem[top_idx];
    assign bus.PEEK_VALID = (bus.PEEK_IDX < level);
    assign bus.PEEK_OUT   = bus.PEEK_VALID ? mem[peek_idx] : '0;
endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed scenarios plus a randomized run
// against a queue-based LIFO model, on an 8x8 instance and a 16-bit x 5 instance.
module tb_param_stack;
    logic CLK;
    logic nRST;

    param_stack_if #(.DATA_WIDTH(8),  .DEPTH(8)) a_if ();
    param_stack_if #(.DATA_WIDTH(16), .DEPTH(5)) b_if ();

    param_stack #(.DATA_WIDTH(8),  .DEPTH(8)) u_a (.CLK(CLK), .nRST(nRST), .bus(a_if.slave));
    param_stack #(.DATA_WIDTH(16), .DEPTH(5)) u_b (.CLK(CLK), .nRST(nRST), .bus(b_if.slave));

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: exp_q[$] is the expected stack, last element = top.
    logic [7:0]  exp_q[$];
    logic [15:0] exp_q_b[$];
    logic        m_ovf, m_unf, m_ovf_b, m_unf_b;

    function automatic logic [7:0] exp_top();
        return (exp_q.size() == 0) ? 8'h00 : exp_q[exp_q.size()-1];
    endfunction

    function automatic logic [7:0] exp_peek(input int idx);
        return (idx < exp_q.size()) ? exp_q[exp_q.size()-1-idx] : 8'h00;
    endfunction

    task automatic idle_inputs();
        a_if.CE = 1'b1; a_if.SOFT_CLR = 1'b0; a_if.PUSH = 1'b0; a_if.POP = 1'b0;
        a_if.CLR_ERR = 1'b0; a_if.DATA_IN = '0;
        b_if.CE = 1'b1; b_if.SOFT_CLR = 1'b0; b_if.PUSH = 1'b0; b_if.POP = 1'b0;
        b_if.CLR_ERR = 1'b0; b_if.DATA_IN = '0;
    endtask

    // Driver for instance A: one clock edge with the given command, model updated alongside.
    task automatic step_a(input logic ce, input logic sclr, input logic push, input logic pop,
                          input logic [7:0] din, input logic clr);
        logic new_ovf, new_unf;
        @(negedge CLK);
        a_if.CE = ce; a_if.SOFT_CLR = sclr; a_if.PUSH = push; a_if.POP = pop;
        a_if.DATA_IN = din; a_if.CLR_ERR = clr;
        @(posedge CLK);
        if (ce) begin
            new_ovf = 1'b0; new_unf = 1'b0;
            if (sclr) exp_q.delete();
            else if (push && !pop) begin
                if (exp_q.size() == 8) new_ovf = 1'b1; else exp_q.push_back(din);
            end else if (pop && !push) begin
                if (exp_q.size() == 0) new_unf = 1'b1; else void'(exp_q.pop_back());
            end else if (push && pop) begin
                if (exp_q.size() == 0) exp_q.push_back(din); else exp_q[exp_q.size()-1] = din;
            end
            m_ovf = new_ovf || (m_ovf && !clr);
            m_unf = new_unf || (m_unf && !clr);
        end
        #1;
        idle_inputs();
    endtask

    // Driver for instance B (depth 5) with its own model.
    task automatic step_b(input logic push, input logic pop, input logic [15:0] din);
        @(negedge CLK);
        b_if.PUSH = push; b_if.POP = pop; b_if.DATA_IN = din;
        @(posedge CLK);
        if (push && !pop) begin
            if (exp_q_b.size() == 5) m_ovf_b = 1'b1; else exp_q_b.push_back(din);
        end else if (pop && !push) begin
            if (exp_q_b.size() == 0) m_unf_b = 1'b1; else void'(exp_q_b.pop_back());
        end
        #1;
        idle_inputs();
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        nRST = 1'b0;
        exp_q.delete(); exp_q_b.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRST = 1'b0;
        exp_q.delete(); exp_q_b.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
        a_if.PEEK_IDX = '0;
        #2;
        n_checks++; if (a_if.LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", a_if.LEVEL); end
        n_checks++; if (a_if.EMPTY !== 1'b1 || a_if.FULL !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", a_if.EMPTY, a_if.FULL); end
        n_checks++; if (a_if.OVF !== 1'b0 || a_if.UNF !== 1'b0) begin n_fail++; $display("FAIL reset_err: ovf=%b unf=%b want 0/0", a_if.OVF, a_if.UNF); end
        n_checks++; if (a_if.DATA_OUT !== 8'h00 || a_if.PEEK_OUT !== 8'h00 || a_if.PEEK_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_outs: dout=%h peek=%h pv=%b want 00/00/0", a_if.DATA_OUT, a_if.PEEK_OUT, a_if.PEEK_VALID); end
        n_checks++; if (b_if.LEVEL !== 3'd0 || b_if.EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_b: level=%0d empty=%b want 0/1", b_if.LEVEL, b_if.EMPTY); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_basic_push_peek();
        apply_reset();
        step_a(1, 0, 1, 0, 8'h11, 0);
        step_a(1, 0, 1, 0, 8'h22, 0);
        step_a(1, 0, 1, 0, 8'h33, 0);
        n_checks++; if (a_if.LEVEL !== 4'd3) begin n_fail++; $display("FAIL basic_level: got %0d want 3", a_if.LEVEL); end
        n_checks++; if (a_if.DATA_OUT !== 8'h33) begin n_fail++; $display("FAIL basic_top: got %h want 33", a_if.DATA_OUT); end
        n_checks++; if (a_if.EMPTY !== 1'b0 || a_if.FULL !== 1'b0) begin n_fail++; $display("FAIL basic_flags: empty=%b full=%b want 0/0", a_if.EMPTY, a_if.FULL); end
        a_if.PEEK_IDX = 4'd2; #1;
        n_checks++; if (a_if.PEEK_OUT !== 8'h11 || a_if.PEEK_VALID !== 1'b1) begin n_fail++; $display("FAIL basic_peek2: got %h/%b want 11/1", a_if.PEEK_OUT, a_if.PEEK_VALID); end
        a_if.PEEK_IDX = 4'd3; #1;
        n_checks++; if (a_if.PEEK_OUT !== 8'h00 || a_if.PEEK_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_peek3: got %h/%b want 00/0", a_if.PEEK_OUT, a_if.PEEK_VALID); end
        a_if.PEEK_IDX = '0;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 8; i++) step_a(1, 0, 1, 0, 8'(i), 0);
        step_a(1, 0, 1, 0, 8'hFF, 0);
        n_checks++; if (a_if.FULL !== 1'b1 || a_if.LEVEL !== 4'd8) begin n_fail++; $display("FAIL ovf_full: full=%b level=%0d want 1/8", a_if.FULL, a_if.LEVEL); end
        n_checks++; if (a_if.DATA_OUT !== 8'h08 || a_if.OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set: dout=%h ovf=%b want 08/1", a_if.DATA_OUT, a_if.OVF); end
        step_a(1, 0, 0, 1, 8'h00, 0);
        n_checks++; if (a_if.LEVEL !== 4'd7 || a_if.DATA_OUT !== 8'h07 || a_if.OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_pop: level=%0d dout=%h ovf=%b want 7/07/1", a_if.LEVEL, a_if.DATA_OUT, a_if.OVF); end
        step_a(1, 0, 0, 0, 8'h00, 1);
        n_checks++; if (a_if.OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", a_if.OVF); end
    endtask

    task automatic test_underflow_replace_empty();
        apply_reset();
        step_a(1, 0, 0, 1, 8'h00, 0);
        n_checks++; if (a_if.UNF !== 1'b1 || a_if.LEVEL !== 4'd0 || a_if.DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL unf_set: unf=%b level=%0d dout=%h want 1/0/00", a_if.UNF, a_if.LEVEL, a_if.DATA_OUT); end
        step_a(1, 0, 1, 1, 8'h5A, 0);
        n_checks++; if (a_if.LEVEL !== 4'd1 || a_if.DATA_OUT !== 8'h5A || a_if.UNF !== 1'b1) begin n_fail++; $display("FAIL replace_empty: level=%0d dout=%h unf=%b want 1/5a/1", a_if.LEVEL, a_if.DATA_OUT, a_if.UNF); end
    endtask

    task automatic test_replace_full();
        apply_reset();
        for (int i = 1; i <= 8; i++) step_a(1, 0, 1, 0, 8'(i), 0);
        step_a(1, 0, 1, 1, 8'hAB, 0);
        n_checks++; if (a_if.LEVEL !== 4'd8 || a_if.DATA_OUT !== 8'hAB || a_if.OVF !== 1'b0) begin n_fail++; $display("FAIL replace_full: level=%0d dout=%h ovf=%b want 8/ab/0", a_if.LEVEL, a_if.DATA_OUT, a_if.OVF); end
        a_if.PEEK_IDX = 4'd1; #1;
        n_checks++; if (a_if.PEEK_OUT !== 8'h07) begin n_fail++; $display("FAIL replace_peek1: got %h want 07", a_if.PEEK_OUT); end
        a_if.PEEK_IDX = '0;
    endtask

    task automatic test_ce_softclr_async();
        apply_reset();
        step_a(1, 0, 1, 0, 8'h10, 0);
        step_a(1, 0, 1, 0, 8'h20, 0);
        step_a(1, 0, 1, 0, 8'h30, 0);
        step_a(1, 0, 1, 0, 8'h40, 0);
        step_a(0, 0, 1, 0, 8'h99, 0);
        n_checks++; if (a_if.LEVEL !== 4'd4 || a_if.DATA_OUT !== 8'h40) begin n_fail++; $display("FAIL ce_hold: level=%0d dout=%h want 4/40", a_if.LEVEL, a_if.DATA_OUT); end
        step_a(1, 1, 1, 0, 8'h77, 0);
        n_checks++; if (a_if.LEVEL !== 4'd0 || a_if.EMPTY !== 1'b1) begin n_fail++; $display("FAIL soft_clr: level=%0d empty=%b want 0/1", a_if.LEVEL, a_if.EMPTY); end
        step_a(1, 0, 1, 0, 8'hC1, 0);
        step_a(1, 0, 1, 0, 8'hC2, 0);
        n_checks++; if (a_if.LEVEL !== 4'd2) begin n_fail++; $display("FAIL pre_async_level: got %0d want 2", a_if.LEVEL); end
        #2;
        nRST = 1'b0;
        exp_q.delete(); exp_q_b.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        n_checks++; if (a_if.LEVEL !== 4'd0 || a_if.DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL async_reset: level=%0d dout=%h want 0/00", a_if.LEVEL, a_if.DATA_OUT); end
        @(negedge CLK);
        nRST = 1'b1;
        step_a(1, 0, 1, 0, 8'hE1, 0);
        n_checks++; if (a_if.LEVEL !== 4'd1 || a_if.DATA_OUT !== 8'hE1) begin n_fail++; $display("FAIL post_reset_push: level=%0d dout=%h want 1/e1", a_if.LEVEL, a_if.DATA_OUT); end
    endtask

    task automatic test_err_priority();
        apply_reset();
        for (int i = 0; i < 8; i++) step_a(1, 0, 1, 0, 8'hA0 + 8'(i), 0);
        step_a(1, 0, 1, 0, 8'hEE, 1);
        n_checks++; if (a_if.OVF !== 1'b1) begin n_fail++; $display("FAIL new_err_wins: ovf=%b want 1", a_if.OVF); end
        step_a(0, 0, 0, 0, 8'h00, 1);
        n_checks++; if (a_if.OVF !== 1'b1) begin n_fail++; $display("FAIL ce_holds_flag: ovf=%b want 1", a_if.OVF); end
        step_a(1, 1, 0, 1, 8'h00, 0);
        n_checks++; if (a_if.OVF !== 1'b1 || a_if.UNF !== 1'b0 || a_if.LEVEL !== 4'd0) begin n_fail++; $display("FAIL softclr_flags: ovf=%b unf=%b level=%0d want 1/0/0", a_if.OVF, a_if.UNF, a_if.LEVEL); end
    endtask

    task automatic test_param_sweep();
        apply_reset();
        for (int i = 0; i < 5; i++) step_b(1, 0, 16'h1234);
        n_checks++; if (b_if.FULL !== 1'b1 || b_if.LEVEL !== 3'd5) begin n_fail++; $display("FAIL sweep_full: full=%b level=%0d want 1/5", b_if.FULL, b_if.LEVEL); end
        n_checks++; if (b_if.DATA_OUT !== 16'h1234) begin n_fail++; $display("FAIL sweep_top: got %h want 1234", b_if.DATA_OUT); end
        step_b(1, 0, 16'hBEEF);
        n_checks++; if (b_if.OVF !== 1'b1 || b_if.LEVEL !== 3'd5) begin n_fail++; $display("FAIL sweep_ovf: ovf=%b level=%0d want 1/5", b_if.OVF, b_if.LEVEL); end
        for (int i = 0; i < 5; i++) step_b(0, 1, 16'h0000);
        n_checks++; if (b_if.EMPTY !== 1'b1 || b_if.UNF !== 1'b0) begin n_fail++; $display("FAIL sweep_drain: empty=%b unf=%b want 1/0", b_if.EMPTY, b_if.UNF); end
        n_checks++; if (b_if.LEVEL !== 3'(exp_q_b.size()) || b_if.OVF !== m_ovf_b) begin n_fail++; $display("FAIL sweep_model: level=%0d ovf=%b want %0d/%b", b_if.LEVEL, b_if.OVF, exp_q_b.size(), m_ovf_b); end
    endtask

    task automatic test_random();
        int idx;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            step_a($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom), $urandom_range(0, 9) == 0);
            idx = $urandom_range(0, 9);
            a_if.PEEK_IDX = 4'(idx);
            #1;
            n_checks++;
            if (a_if.LEVEL !== 4'(exp_q.size()) || a_if.DATA_OUT !== exp_top() ||
                a_if.EMPTY !== (exp_q.size() == 0) || a_if.FULL !== (exp_q.size() == 8) ||
                a_if.OVF !== m_ovf || a_if.UNF !== m_unf ||
                a_if.PEEK_VALID !== (idx < exp_q.size()) || a_if.PEEK_OUT !== exp_peek(idx)) begin
                n_fail++;
                $display("FAIL random_step%0d: level=%0d dout=%h e/f=%b%b ovf/unf=%b%b peek[%0d]=%h/%b want level=%0d dout=%h ovf/unf=%b%b peek=%h",
                         n, a_if.LEVEL, a_if.DATA_OUT, a_if.EMPTY, a_if.FULL, a_if.OVF, a_if.UNF,
                         idx, a_if.PEEK_OUT, a_if.PEEK_VALID, exp_q.size(), exp_top(), m_ovf, m_unf, exp_peek(idx));
            end
        end
        a_if.PEEK_IDX = '0;
    endtask

    initial begin
        nRST = 1'b1;
        idle_inputs();
        a_if.PEEK_IDX = '0;
        b_if.PEEK_IDX = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
        test_reset();
        test_basic_push_peek();
        test_overflow();
        test_underflow_replace_empty();
        test_replace_full();
        test_ce_softclr_async();
        test_err_priority();
        test_param_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
